mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Four-channel, 16-bit round-robin arbiter with a registered output stage. It sits directly upstream of the 4:1 data-select stage: it picks one of four valid/ready source channels, registers the winning beat, and presents the beat with its 2-bit channel select. Bursts are lock-granted, so a multi-beat transfer (terminated by `last`) is never interleaved with another channel.

## Interface
- `WIDTH`, 16, data width per channel.
- `SEL_WIDTH`, 2, width of the channel select / index.
- `NUM_CH`, 4, number of channels; fixed at 4, other values unsupported.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  NUM_CH  per-channel beat valid.
- `in_last`  in  NUM_CH  per-channel end-of-burst marker, qualified by `in_valid`.
- `data0`..`data3`  in  WIDTH  channel payloads.
- `in_ready`  out  NUM_CH  per-channel accept; one-hot or zero.
- `out_valid`  out  1  registered beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  WIDTH  registered winning payload.
- `out_last`  out  1  registered `last` of the winning beat.
- `out_sel`  out  SEL_WIDTH  index of the channel that supplied `out_data`.

## Operation
- **Handshakes.**
  - Transfer on an input channel when `in_valid[i] && in_ready[i]`.
  - Transfer on the output when `out_valid && out_ready`.
  - Sources must not make `in_valid` depend on `in_ready`. Once `in_valid` is asserted, it and the data stay stable until accepted.
- **Load enable.** `load = !out_valid || out_ready`. The output register accepts a new beat whenever it is empty or being drained in the same cycle.
- **Grant, unlocked state.**
  - Rotate priority starting at `ptr+1` mod 4, where `ptr` is the last granted channel.
  - Grant the first channel with `in_valid` set.
- **Grant, locked state.** Grant only `lock_ch`. Other channels see `in_ready=0` even when valid.
- **Ready.** `in_ready[g] = load && in_valid[g]` for the granted channel `g`. All other bits are 0.
- **On an accepted input beat:**
  - `out_data`, `out_last` and `out_sel` take the granted channel's values.
  - `out_valid` becomes 1.
  - `ptr` becomes `g`.
- **Lock state machine (UNLOCKED / LOCKED):**
  - UNLOCKED -> LOCKED: accepted beat with `in_last=0`; `lock_ch` becomes `g`.
  - LOCKED -> UNLOCKED: accepted beat from `lock_ch` with `in_last=1`.
  - LOCKED, `lock_ch` not valid: nothing is granted and the state holds, even if other channels are valid.
  - A single beat with `in_last=1` never locks.
- **Output drain.** `out_valid` clears when the output transfers and no new beat loads in that cycle.
- **No valid input.** No grant, and `ptr` is unchanged.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, `in_ready=0`.
  - `ptr=3`, so channel 0 has first priority.
  - State UNLOCKED, `lock_ch=0`.
- **Latency and throughput.** Input accept to `out_valid` is 1 cycle. Sustained throughput is 1 beat/cycle while `out_ready=1`.
- **Combinational paths.** `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and the lock state. There is no path from any data input to `in_ready`.
- **Simultaneous drain and load.** Output drain and input load in the same cycle give back-to-back beats with no bubble.
- **Backpressure.** With `out_ready=0` and `out_valid=1`, all `in_ready` bits are 0 and the output register holds.
- **Reset mid-burst.** Asserting `rst` during a locked burst clears the lock and pointer immediately. The partial burst is abandoned, and sources restart after reset deasserts.

## Structure
- **Package `mux_pkg`:**
  - Constants `MUX_WIDTH=16`, `MUX_SEL_WIDTH=2`, `MUX_NUM_CH=4`.
  - Enum `lock_state_t {UNLOCKED, LOCKED}`.
- **Sub-module `rr_pick4`.** Combinational 4-way rotating-priority picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant, 2-bit index, and `any`.
- **Top level.** Holds the lock FSM, the pointer, the output register and the payload select.

## Test plan
- **Reset priority.** After reset, `in_valid=4'b1111`, all `last=1`, `out_ready=1`, `data i = 16'hA000+i`. Outputs are `16'hA000`, `A001`, `A002`, `A003`, `A000` on consecutive cycles; `out_sel` is 0,1,2,3,0.
- **Burst lock.** Ch2 sends a 3-beat burst (`last` = 0,0,1) while ch0 and ch1 are continuously valid. All three ch2 beats emerge contiguously with `out_sel=2`, then ch0 is granted next.
- **Backpressure.** Hold `out_ready=0` for 5 cycles with `out_valid=1`. `out_data`/`out_sel` are stable, `in_ready=0`. After release, one beat per cycle resumes with no loss or duplication.
- **Locked, owner idle.** Ch1 is locked (first beat `last=0`), then ch1 `in_valid` drops for 4 cycles while ch3 is valid. Ch3 is not granted; the ch1 `last=1` beat is then accepted and ch3 follows.
- **Reset mid-burst.** Assert `rst` after beat 1 of a ch3 burst. Outputs return to reset values, and the next grant goes to ch0 if it is valid.
- **Idle channels.** Only ch1 is valid with `data1=16'h5A5A`. Output is `16'h5A5A`, `out_sel=1`, 1 cycle after accept; `ptr` stays at 1 while `in_valid=0`.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and lock-state type for the 4-channel round-robin arbiter
package mux_pkg;
    localparam int MUX_WIDTH     = 16;
    localparam int MUX_SEL_WIDTH = 2;
    localparam int MUX_NUM_CH    = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;
endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way rotating-priority picker
// Priority starts at ptr+1 and wraps, so the last winner is served last.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [MUX_NUM_CH-1:0]    req,
    input  logic [MUX_SEL_WIDTH-1:0] ptr,
    output logic [MUX_NUM_CH-1:0]    grant,
    output logic [MUX_SEL_WIDTH-1:0] idx,
    output logic                     any
);
    always_comb begin
        logic [MUX_SEL_WIDTH-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int k = MUX_NUM_CH; k >= 1; k--) begin
            cand = ptr + MUX_SEL_WIDTH'(k);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - 4-channel round-robin arbiter with burst lock and registered output
module mux4_rr_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH     = MUX_WIDTH,
    parameter int SEL_WIDTH = MUX_SEL_WIDTH,
    parameter int NUM_CH    = MUX_NUM_CH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH-1:0]    in_last,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic [WIDTH-1:0]     data3,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SEL_WIDTH-1:0] out_sel
);
    lock_state_t          state_q, state_d;
    logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;

    logic [NUM_CH-1:0]    pick_grant;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_any;

    logic                 load;
    logic                 accept;
    logic [NUM_CH-1:0]    grant_vec;
    logic [SEL_WIDTH-1:0] g_idx;
    logic                 g_any;
    logic [WIDTH-1:0]     g_data;
    logic                 g_last;

    rr_pick4 u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant depends only on valids, lock state and output occupancy, never on payload.
    always_comb begin
        load      = !out_valid_q || out_ready;
        grant_vec = '0;
        if (state_q == LOCKED) begin
            g_idx            = lock_ch_q;
            g_any            = in_valid[lock_ch_q];
            grant_vec[g_idx] = g_any;
        end else begin
            g_idx     = pick_idx;
            g_any     = pick_any;
            grant_vec = pick_grant;
        end
        accept   = load && g_any;
        in_ready = load ? grant_vec : '0;
    end

    always_comb begin
        case (g_idx)
            2'd0:    g_data = data0;
            2'd1:    g_data = data1;
            2'd2:    g_data = data2;
            default: g_data = data3;
        endcase
        g_last = in_last[g_idx];
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = g_data;
            out_last_d  = g_last;
            out_sel_d   = g_idx;
            ptr_d       = g_idx;
            if (state_q == UNLOCKED && !g_last) begin
                state_d   = LOCKED;
                lock_ch_d = g_idx;
            end else if (state_q == LOCKED && g_last) begin
                state_d = UNLOCKED;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            lock_ch_q   <= '0;
            ptr_q       <= SEL_WIDTH'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter against a behavioural arbitration model
module tb_mux4_rr_arbiter;
    typedef struct {
        logic [15:0] data;
        logic        last;
        int          delay;
    } beat_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [15:0] data0, data1, data2, data3;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  out_sel;

    mux4_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    beat_t       src_q [4][$];
    exp_t        sbq [$];
    logic [1:0]  obs_sel [$];
    logic [15:0] obs_data [$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_mode = 0;
    int   m_ptr    = 3;
    bit   m_locked = 0;
    int   m_owner  = 0;
    bit   m_ov     = 0;
    exp_t m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_beat(input int c, input logic [15:0] d, input logic l, input int dly);
        beat_t b;
        b.data = d; b.last = l; b.delay = dly;
        src_q[c].push_back(b);
    endtask

    // One clock: drive sources, then predict the grant from the round-robin and lock rules.
    task automatic cycle();
        logic [3:0]  v, l;
        logic [15:0] d [4];
        logic [3:0]  exp_rdy;
        beat_t       b;
        exp_t        e;
        int          win, c;
        bit          load;
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            v[ch] = 1'b0; l[ch] = 1'b0; d[ch] = 16'($urandom);
            if (src_q[ch].size() > 0) begin
                b = src_q[ch][0];
                if (b.delay > 0) begin
                    b.delay--;
                    src_q[ch][0] = b;
                end else begin
                    v[ch] = 1'b1; l[ch] = b.last; d[ch] = b.data;
                end
            end
        end
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b0;
        endcase
        in_valid = v; in_last = l;
        data0 = d[0]; data1 = d[1]; data2 = d[2]; data3 = d[3];
        #1;
        load = !m_ov || out_ready;
        win  = -1;
        if (m_locked) begin
            if (v[m_owner]) win = m_owner;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_ptr + k) % 4;
                if (v[c] && win < 0) win = c;
            end
        end
        exp_rdy = (load && win >= 0) ? 4'(1 << win) : 4'b0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data_held", 32'(out_data), 32'(m_cur.data));
            chk("out_sel_held", 32'(out_sel), 32'(m_cur.sel));
        end
        if (load && win >= 0) begin
            b = src_q[win].pop_front();
            e.data = b.data; e.last = b.last; e.sel = 2'(win);
            sbq.push_back(e);
            m_cur = e;
            m_ov  = 1'b1;
            m_ptr = win;
            if (!m_locked && !b.last) begin
                m_locked = 1'b1;
                m_owner  = win;
            end else if (m_locked && b.last) begin
                m_locked = 1'b0;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_sel", 32'(out_sel), 32'(e.sel));
                chk("sb_last", 32'(out_last), 32'(e.last));
                obs_sel.push_back(out_sel);
                obs_data.push_back(out_data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 4'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        for (int ch = 0; ch < 4; ch++) src_q[ch].delete();
        sbq.delete(); obs_sel.delete(); obs_data.delete();
        m_ptr = 3; m_locked = 1'b0; m_owner = 0; m_ov = 1'b0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_drain(input int budget);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n++;
            busy = m_ov || (sbq.size() != 0);
            for (int ch = 0; ch < 4; ch++) if (src_q[ch].size() != 0) busy = 1'b1;
        end
        chk("drain_done", 32'(busy), 32'd0);
    endtask

    task automatic check_sels(input string name, input int n, input logic [15:0] seq);
        chk({name, "_count"}, 32'(obs_sel.size()), 32'(n));
        for (int i = 0; i < n && i < obs_sel.size(); i++)
            chk(name, 32'(obs_sel[i]), 32'(seq[2*(n-1-i) +: 2]));
    endtask

    initial begin
        logic [1:0] rp_sel [5];
        int         len;
        int         ch;
        rst = 1'b1; in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        repeat (2) @(negedge clk);

        do_reset();
        push_beat(0, 16'hA000, 1'b1, 0);
        push_beat(1, 16'hA001, 1'b1, 0);
        push_beat(2, 16'hA002, 1'b1, 0);
        push_beat(3, 16'hA003, 1'b1, 0);
        push_beat(0, 16'hA000, 1'b1, 0);
        run_drain(50);
        check_sels("rst_prio_sel", 5, {6'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        rp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5 && i < obs_data.size(); i++)
            chk("rst_prio_data", 32'(obs_data[i]), 32'(16'hA000 + 16'(rp_sel[i])));

        do_reset();
        push_beat(2, 16'h2200, 1'b0, 0);
        push_beat(2, 16'h2201, 1'b0, 0);
        push_beat(2, 16'h2202, 1'b1, 0);
        push_beat(0, 16'h0000, 1'b1, 1);
        push_beat(1, 16'h1100, 1'b1, 1);
        run_drain(50);
        check_sels("burst_lock", 5, {6'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1});

        do_reset();
        for (int j = 0; j < 3; j++) begin
            push_beat(0, 16'h0B00 + 16'(j), 1'b1, 0);
            push_beat(1, 16'h0B10 + 16'(j), 1'b1, 0);
        end
        cycle();
        rdy_mode = 2;
        repeat (5) cycle();
        rdy_mode = 0;
        run_drain(50);
        check_sels("backpressure", 6, {4'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1});

        do_reset();
        push_beat(1, 16'hB100, 1'b0, 0);
        push_beat(1, 16'hB101, 1'b1, 4);
        push_beat(3, 16'hC300, 1'b1, 1);
        run_drain(50);
        check_sels("owner_idle", 3, {10'd0, 2'd1, 2'd1, 2'd3});

        do_reset();
        push_beat(3, 16'hC000, 1'b0, 0);
        push_beat(3, 16'hC001, 1'b0, 0);
        push_beat(3, 16'hC002, 1'b1, 0);
        push_beat(0, 16'hA0A0, 1'b1, 5);
        cycle();
        do_reset();
        push_beat(3, 16'hD003, 1'b1, 0);
        push_beat(0, 16'hD000, 1'b1, 0);
        run_drain(50);
        check_sels("rst_midburst", 2, {12'd0, 2'd0, 2'd3});

        do_reset();
        push_beat(1, 16'h5A5A, 1'b1, 0);
        push_beat(0, 16'h1111, 1'b1, 4);
        push_beat(2, 16'h2222, 1'b1, 4);
        run_drain(50);
        check_sels("idle_ptr", 3, {10'd0, 2'd1, 2'd2, 2'd0});
        if (obs_data.size() > 0) chk("idle_data", 32'(obs_data[0]), 32'h5A5A);

        do_reset();
        rdy_mode = 1;
        for (int bu = 0; bu < 40; bu++) begin
            ch  = $urandom_range(0, 3);
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
                push_beat(ch, 16'($urandom), (j == len - 1), $urandom_range(0, 2));
        end
        run_drain(3000);
        rdy_mode = 0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
